puf_challenge_sequencer: RTL and testbench
==========================================

// Module: puf_challenge_sequencer
// PURPOSE
//  Initiator side of the RO-PUF challenge/response interface. Walks a run of 5-bit
//  challenges and gates the two oscillator banks for a fixed window per challenge.
//  Samples the two bank counters and turns each comparison into one response bit.
//  Packs 8 bits per byte and streams the bytes out with a valid/ready handshake.
// PARAMETERS
//  CNT_W          16    width of each bank counter input
//  WINDOW_CYCLES  1024  clk cycles osc_en is held high per challenge (>=1)
//  SETTLE_CYCLES  4     clk cycles after osc_en falls before sampling counts (>=2)
//  NUM_BYTES      4     response bytes per run (NUM_BYTES*8 challenges, <=4 => no repeat)
// PORTS
//  clk          in   1      system clock
//  rst_n        in   1      asynchronous active-low reset
//  start        in   1      one-cycle pulse, accepted only in IDLE
//  chal_base    in   5      first challenge of the run, latched on accepted start
//  count_a      in   CNT_W  bank A counter (oscillator domain, stable only when osc_en=0)
//  count_b      in   CNT_W  bank B counter
//  osc_en       out  1      enable to both oscillator banks
//  cnt_clr      out  1      clear to both bank counters (active high)
//  challenge    out  5      mux select to both banks
//  resp_byte    out  8      packed response, first bit in bit 0
//  resp_valid   out  1      resp_byte holds a new byte
//  resp_ready   in   1      consumer accepts byte when resp_valid & resp_ready
//  busy         out  1      high in every state except IDLE
//  tie_seen     out  1      sticky: some challenge in this run gave count_a==count_b
// BEHAVIOUR
//  Reset: osc_en=0, cnt_clr=1, challenge=0, resp_byte=0, resp_valid=0, busy=0,
//   tie_seen=0, FSM=IDLE, all internal counters 0.
//  FSM: IDLE -> CLEAR -> RUN -> SETTLE -> CMP -> (CLEAR | EMIT) ; EMIT -> (CLEAR | IDLE).
//  IDLE: cnt_clr=1, osc_en=0. On start, latch chal_base into challenge, clear tie_seen
//   and the bit/byte indices, then go to CLEAR. start outside IDLE is ignored.
//  CLEAR: 1 cycle, cnt_clr=1. challenge is stable from here until CMP exits.
//  RUN: cnt_clr=0, osc_en=1 for exactly WINDOW_CYCLES cycles.
//  SETTLE: osc_en=0 for SETTLE_CYCLES cycles. Counts are sampled only after this
//   (crossing is quasi-static, no synchroniser on the count buses).
//  CMP: 1 cycle. bit = (count_a > count_b) on CNT_W-bit unsigned compare.
//   Equal counts give bit=0 and set tie_seen.
//   Shift the bit into shreg[bit_idx], then bit_idx++ and challenge <= challenge+1
//   (5-bit wrap, 31->0).
//   bit_idx==7 -> EMIT and bit_idx<=0; otherwise -> CLEAR.
//  EMIT: resp_byte<=shreg, resp_valid=1, cnt_clr=1, osc_en=0.
//   resp_byte and resp_valid are held stable until the handshake.
//   On valid&ready: resp_valid<=0 next cycle and byte_idx++.
//   byte_idx==NUM_BYTES-1 -> IDLE; otherwise -> CLEAR.
//   Back-pressure stalls the sequencer with no measurement running.
//  Latency per byte, with resp_ready held high: 8*(WINDOW_CYCLES+SETTLE_CYCLES+2)+1 clks.
//  Counter saturation: none here. A wrapped bank counter gives a meaningless bit, and
//   integration must size CNT_W against WINDOW_CYCLES.
//  Reset mid-run: immediate return to reset state, osc_en drops asynchronously,
//   and any partial byte is discarded.
//  busy=0 only in IDLE. tie_seen stays valid after the run, until the next start.
// STRUCTURE
//  Shared package puf_pkg: state enum (IDLE, CLEAR, RUN, SETTLE, CMP, EMIT),
//   CHAL_W=5, RESP_W=8.
//  One sub-module: puf_window_timer. It is a loadable down-counter with a done flag,
//   reused for both the RUN and SETTLE phases.
//  Everything else is a single FSM plus datapath in this file.
// TESTING (behavioural bank model: count = k_chal * cycles enabled)
//  1 Reset, then start with chal_base=0. Model A>B on even challenges, A<B on odd.
//    -> byte0=8'h55, challenges step 0..7, osc_en high for exactly 1024 clks each.
//  2 chal_base=30, NUM_BYTES=1 -> challenge sequence 30,31,0,1,...,5 (wrap checked).
//  3 resp_ready held low for 500 clks in EMIT -> resp_byte stable, osc_en=0 throughout,
//    and the next CLEAR follows only after ready.
//  4 Model count_a==count_b on challenge 3 -> bit3=0 and tie_seen=1 until the next start.
//  5 rst_n low in mid-RUN of bit 5 -> osc_en=0, busy=0 and resp_valid=0 immediately.
//    A fresh start then restarts from chal_base.
//  6 start pulsed while busy -> ignored: chal_base is not re-latched and the byte count
//    is unchanged.

Source files
------------

// File: rtl/puf_pkg.sv
// Shared definitions for the RO-PUF challenge sequencer.
//   state_t : sequencer FSM states
//   CHAL_W  : challenge (oscillator mux select) width
//   RESP_W  : response bits packed per output byte
package puf_pkg;

    localparam int CHAL_W = 5;
    localparam int RESP_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_RUN,
        ST_SETTLE,
        ST_CMP,
        ST_EMIT
    } state_t;

endpackage

// File: rtl/puf_window_timer.sv
// Loadable down-counter used to time both the oscillator window and the settle gap.
//   clk      : system clock
//   rst_n    : asynchronous active-low reset
//   load     : load load_val this cycle (takes priority over counting)
//   load_val : remaining cycles minus one for the phase being entered
//   done     : counter has reached zero (last cycle of the timed phase)
module puf_window_timer #(
    parameter int W = 11
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign done = (cnt == '0);

endmodule

// File: rtl/puf_challenge_sequencer.sv
// Initiator side of the RO-PUF challenge/response interface. Steps through a run of
// challenges, gates both oscillator banks for a fixed window, compares the bank counts
// after a settle gap and packs one response bit per challenge into bytes that are
// streamed out over a valid/ready handshake.
//   clk, rst_n        : system clock, asynchronous active-low reset
//   start, chal_base  : run request (honoured in IDLE only) and first challenge
//   count_a, count_b  : bank counters, read only while the oscillators are stopped
//   osc_en, cnt_clr   : oscillator enable and counter clear to both banks
//   challenge         : mux select to both banks
//   resp_byte/valid   : packed response (first bit in bit 0) and its valid flag
//   resp_ready        : consumer accept
//   busy, tie_seen    : not IDLE; sticky equal-count flag for the current/last run
//
// state     | meaning
// ----------+-------------------------------------------------------------
// ST_IDLE   | waiting for start, counters held clear
// ST_CLEAR  | one-cycle counter clear with the new challenge applied
// ST_RUN    | oscillators enabled for WINDOW_CYCLES
// ST_SETTLE | oscillators stopped, letting the count buses go quiet
// ST_CMP    | compare counts, store the bit, advance the challenge
// ST_EMIT   | present the finished byte, wait for the consumer
module puf_challenge_sequencer
    import puf_pkg::*;
#(
    parameter int CNT_W         = 16,
    parameter int WINDOW_CYCLES = 1024,
    parameter int SETTLE_CYCLES = 4,
    parameter int NUM_BYTES     = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [CHAL_W-1:0] chal_base,
    input  logic [CNT_W-1:0]  count_a,
    input  logic [CNT_W-1:0]  count_b,
    output logic              osc_en,
    output logic              cnt_clr,
    output logic [CHAL_W-1:0] challenge,
    output logic [RESP_W-1:0] resp_byte,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic              busy,
    output logic              tie_seen
);

    localparam int TMR_MAX = (WINDOW_CYCLES > SETTLE_CYCLES) ? WINDOW_CYCLES : SETTLE_CYCLES;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);
    localparam int BIT_W   = $clog2(RESP_W);
    localparam int BYTE_W  = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;

    // Timer is loaded with length-1 so the phase ends on the cycle done is seen.
    localparam logic [TMR_W-1:0]  RUN_LOAD    = TMR_W'(WINDOW_CYCLES - 1);
    localparam logic [TMR_W-1:0]  SETTLE_LOAD = TMR_W'(SETTLE_CYCLES - 1);
    localparam logic [BIT_W-1:0]  LAST_BIT    = BIT_W'(RESP_W - 1);
    localparam logic [BYTE_W-1:0] LAST_BYTE   = BYTE_W'(NUM_BYTES - 1);

    state_t             state, state_nxt;
    logic [BIT_W-1:0]   bit_idx;
    logic [BYTE_W-1:0]  byte_idx;
    logic [RESP_W-1:0]  shreg, shreg_nxt;
    logic               resp_bit, tie_now;
    logic               tmr_load, tmr_done;
    logic [TMR_W-1:0]   tmr_val;

    puf_window_timer #(.W(TMR_W)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .done     (tmr_done)
    );

    assign resp_bit = (count_a > count_b);
    assign tie_now  = (count_a == count_b);

    always_comb begin
        shreg_nxt          = shreg;
        shreg_nxt[bit_idx] = resp_bit;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Outputs decode straight from the state register so an async reset drops
    // osc_en and resp_valid without waiting for a clock.
    always_comb begin
        state_nxt  = state;
        tmr_load   = 1'b0;
        tmr_val    = '0;
        osc_en     = 1'b0;
        cnt_clr    = 1'b0;
        resp_valid = 1'b0;
        busy       = 1'b1;
        case (state)
            ST_IDLE: begin
                busy    = 1'b0;
                cnt_clr = 1'b1;
                if (start) state_nxt = ST_CLEAR;
            end
            ST_CLEAR: begin
                cnt_clr   = 1'b1;
                tmr_load  = 1'b1;
                tmr_val   = RUN_LOAD;
                state_nxt = ST_RUN;
            end
            ST_RUN: begin
                osc_en = 1'b1;
                if (tmr_done) begin
                    tmr_load  = 1'b1;
                    tmr_val   = SETTLE_LOAD;
                    state_nxt = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (tmr_done) state_nxt = ST_CMP;
            end
            ST_CMP: begin
                state_nxt = (bit_idx == LAST_BIT) ? ST_EMIT : ST_CLEAR;
            end
            ST_EMIT: begin
                cnt_clr    = 1'b1;
                resp_valid = 1'b1;
                if (resp_ready) state_nxt = (byte_idx == LAST_BYTE) ? ST_IDLE : ST_CLEAR;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            challenge <= '0;
            resp_byte <= '0;
            tie_seen  <= 1'b0;
            bit_idx   <= '0;
            byte_idx  <= '0;
            shreg     <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        challenge <= chal_base;
                        tie_seen  <= 1'b0;
                        bit_idx   <= '0;
                        byte_idx  <= '0;
                    end
                end
                ST_CMP: begin
                    shreg     <= shreg_nxt;
                    challenge <= challenge + 1'b1;
                    if (tie_now) tie_seen <= 1'b1;
                    if (bit_idx == LAST_BIT) begin
                        bit_idx   <= '0;
                        resp_byte <= shreg_nxt;
                    end else begin
                        bit_idx <= bit_idx + 1'b1;
                    end
                end
                ST_EMIT: begin
                    if (resp_ready) byte_idx <= byte_idx + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_puf_challenge_sequencer.sv
// Self-checking bench for puf_challenge_sequencer. A bank model turns the challenge
// and the enabled-cycle count into count_a/count_b; a run-level reference model
// predicts the challenge order, response bytes, tie flag and byte latency.
module tb_puf_challenge_sequencer;

    localparam int CNT_W    = 16;
    localparam int WIN      = 40;
    localparam int SET      = 4;
    localparam int NB       = 4;
    localparam int BYTE_LAT = 8 * (WIN + SET + 2) + 1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [4:0]  chal_base = '0;
    logic [15:0] count_a, count_b;
    logic        osc_en, cnt_clr, resp_valid, busy, tie_seen;
    logic        resp_ready = 1'b1;
    logic [4:0]  challenge;
    logic [7:0]  resp_byte;

    int errors = 0;
    int checks = 0;

    puf_challenge_sequencer #(
        .CNT_W(CNT_W), .WINDOW_CYCLES(WIN), .SETTLE_CYCLES(SET), .NUM_BYTES(NB)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .chal_base(chal_base),
        .count_a(count_a), .count_b(count_b), .osc_en(osc_en), .cnt_clr(cnt_clr),
        .challenge(challenge), .resp_byte(resp_byte), .resp_valid(resp_valid),
        .resp_ready(resp_ready), .busy(busy), .tie_seen(tie_seen)
    );

    always #5 clk = ~clk;

    // Bank model: count = k[challenge] * cycles the oscillators have been enabled.
    int ka [32];
    int kb [32];
    int en_cyc = 0;

    always @(posedge clk) begin
        if (cnt_clr)     en_cyc <= 0;
        else if (osc_en) en_cyc <= en_cyc + 1;
    end

    always_comb begin
        count_a = 16'(ka[challenge] * en_cyc);
        count_b = 16'(kb[challenge] * en_cyc);
    end

    // 0 = ready high, 1 = ready low, 2 = random ready
    int ready_mode = 0;
    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       resp_ready = 1'b1;
            1:       resp_ready = 1'b0;
            default: resp_ready = ($urandom_range(0, 3) != 0);
        endcase
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Run-level reference model
    bit         model_busy = 0;
    bit         model_tie  = 0;
    logic [7:0] exp_byte_q[$];
    bit         exp_tie_q[$];
    logic [4:0] exp_chal_q[$];
    logic [7:0] rx_q[$];
    logic [4:0] chal_log[$];

    task automatic model_start(input logic [4:0] b);
        bit t = 0;
        exp_byte_q.delete(); exp_tie_q.delete(); exp_chal_q.delete();
        rx_q.delete(); chal_log.delete();
        for (int j = 0; j < NB; j++) begin
            logic [7:0] byt = '0;
            for (int i = 0; i < 8; i++) begin
                logic [4:0] c = 5'(int'(b) + 8 * j + i);
                exp_chal_q.push_back(c);
                if (ka[c] > kb[c])  byt[i] = 1'b1;
                if (ka[c] == kb[c]) t = 1;
            end
            exp_byte_q.push_back(byt);
            exp_tie_q.push_back(t);
        end
        model_tie  = t;
        model_busy = 1;
    endtask

    // Compare process: every falling edge, outputs against the model.
    int         cyc = 0, mark = 0, run_len = 0;
    bit         prev_valid = 0, prev_hs = 0;
    logic [7:0] prev_byte = '0;
    logic [4:0] cur_chal = '0;

    always @(negedge clk) begin
        if (!rst_n) begin
            model_busy = 0; model_tie = 0;
            exp_byte_q.delete(); exp_tie_q.delete(); exp_chal_q.delete();
            run_len = 0; prev_valid = 0; prev_hs = 0;
        end else begin
            bit hs;
            cyc++;
            check("busy", busy, model_busy);
            if (!model_busy) check("tie_idle", tie_seen, model_tie);
            check("osc_and_clr", osc_en & cnt_clr, 0);
            check("osc_and_valid", osc_en & resp_valid, 0);
            if (osc_en && run_len == 0) begin
                if (exp_chal_q.size() == 0) check("unexpected_window", 1, 0);
                else check("challenge", challenge, exp_chal_q.pop_front());
                chal_log.push_back(challenge);
                cur_chal = challenge;
            end
            if (osc_en) run_len++;
            else if (run_len > 0) begin
                check("window_len", run_len, WIN);
                check("chal_hold", challenge, cur_chal);
                run_len = 0;
            end
            if (resp_valid && !prev_valid) check("byte_latency", cyc - mark, BYTE_LAT);
            if (resp_valid && prev_valid && !prev_hs) check("byte_hold", resp_byte, prev_byte);
            hs = resp_valid && resp_ready;
            if (hs) begin
                if (exp_byte_q.size() == 0) check("unexpected_byte", 1, 0);
                else begin
                    check("resp_byte", resp_byte, exp_byte_q.pop_front());
                    check("tie_byte", tie_seen, exp_tie_q.pop_front());
                    if (exp_byte_q.size() == 0) model_busy = 0;
                end
                rx_q.push_back(resp_byte);
                mark = cyc;
            end
            if (start && !model_busy) begin
                model_start(chal_base);
                mark = cyc;
            end
            prev_valid = resp_valid;
            prev_byte  = resp_byte;
            prev_hs    = hs;
        end
    end

    task automatic do_start(input logic [4:0] b);
        @(posedge clk); #1;
        start = 1'b1; chal_base = b;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (busy && n < budget) begin
            @(negedge clk); n++;
        end
        check("run_timeout", (n >= budget), 0);
        repeat (3) @(negedge clk);
    endtask

    task automatic set_parity();
        for (int c = 0; c < 32; c++) begin
            ka[c] = (c % 2 == 0) ? 5 : 2;
            kb[c] = (c % 2 == 0) ? 3 : 7;
        end
    endtask

    initial begin
        int bad, n;
        set_parity();
        repeat (3) @(posedge clk); #1;
        check("rst_osc_en", osc_en, 0);
        check("rst_cnt_clr", cnt_clr, 1);
        check("rst_challenge", challenge, 0);
        check("rst_resp_byte", resp_byte, 0);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_tie_seen", tie_seen, 0);
        rst_n = 1'b1;

        // A>B on even challenges, base 0
        do_start(5'd0);
        wait_done(20000);
        check("s1_nbytes", rx_q.size(), NB);
        check("s1_byte0", rx_q[0], 8'h55);
        for (int i = 0; i < 8; i++) check("s1_chal_step", chal_log[i], 5'(i));

        // wrap 31 -> 0, A>B only below 16
        for (int c = 0; c < 32; c++) begin ka[c] = (c < 16) ? 9 : 3; kb[c] = 6; end
        do_start(5'd30);
        wait_done(20000);
        check("s2_byte0", rx_q[0], 8'hFC);
        check("s2_chal0", chal_log[0], 5'd30);
        check("s2_chal1", chal_log[1], 5'd31);
        check("s2_chal2", chal_log[2], 5'd0);
        check("s2_chal7", chal_log[7], 5'd5);

        // back-pressure
        set_parity();
        ready_mode = 1;
        do_start(5'd7);
        n = 0;
        while (!resp_valid && n < 5000) begin @(negedge clk); n++; end
        check("s3_valid_timeout", (n >= 5000), 0);
        bad = 0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (osc_en || !resp_valid || !cnt_clr || challenge != 5'(7 + 8)) bad++;
        end
        check("s3_stall_cycles_bad", bad, 0);
        ready_mode = 0;
        wait_done(20000);
        check("s3_nbytes", rx_q.size(), NB);

        // tie on challenge 3
        for (int c = 0; c < 32; c++) begin ka[c] = 9; kb[c] = 4; end
        ka[3] = 6; kb[3] = 6;
        do_start(5'd0);
        wait_done(20000);
        check("s4_byte0", rx_q[0], 8'hF7);
        check("s4_byte1", rx_q[1], 8'hFF);
        check("s4_tie", tie_seen, 1);
        repeat (20) @(negedge clk);
        check("s4_tie_sticky", tie_seen, 1);

        // reset in the middle of bit 5's window
        set_parity();
        do_start(5'd12);
        n = 0;
        while (chal_log.size() < 6 && n < 5000) begin @(negedge clk); n++; end
        check("s5_reach_bit5", (n >= 5000), 0);
        repeat (10) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("s5_osc_en", osc_en, 0);
        check("s5_busy", busy, 0);
        check("s5_valid", resp_valid, 0);
        check("s5_tie_cleared", tie_seen, 0);
        repeat (2) @(posedge clk); #1;
        rst_n = 1'b1;
        do_start(5'd12);
        wait_done(20000);
        check("s5_restart_chal", chal_log[0], 5'd12);
        check("s5_restart_nbytes", rx_q.size(), NB);

        // start while busy is ignored
        do_start(5'd3);
        repeat (100) @(negedge clk);
        do_start(5'd20);
        wait_done(20000);
        check("s6_chal0", chal_log[0], 5'd3);
        check("s6_nchal", chal_log.size(), 32);
        check("s6_nbytes", rx_q.size(), NB);

        // randomized runs
        ready_mode = 2;
        for (int r = 0; r < 6; r++) begin
            for (int c = 0; c < 32; c++) begin
                ka[c] = int'($urandom_range(1, 8));
                kb[c] = int'($urandom_range(1, 8));
            end
            do_start(5'($urandom_range(0, 31)));
            wait_done(30000);
            check("rand_nbytes", rx_q.size(), NB);
        end
        ready_mode = 0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
